rsa_job_scheduler: RTL

RSA_JOB_SCHEDULER -- requirements
Module: rsa_job_scheduler

---
 rtl/rsa_pkg.sv | 18 +
 rtl/rsa_rr_arbiter.sv | 35 +++
 rtl/rsa_job_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared constants and FSM state encoding for the RSA job scheduler.
package rsa_pkg;

    localparam int WIDTH_DEFAULT   = 128;
    localparam int TIMEOUT_DEFAULT = 65535;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_INV_RST   = 3'd1;
    localparam state_t S_INV_GUARD = 3'd2;
    localparam state_t S_INV_WAIT  = 3'd3;
    localparam state_t S_EXP_RST   = 3'd4;
    localparam state_t S_EXP_GUARD = 3'd5;
    localparam state_t S_EXP_WAIT  = 3'd6;
    localparam state_t S_RESP      = 3'd7;

endpackage

// File: rtl/rsa_rr_arbiter.sv
// Two-way round-robin arbiter: grant is combinational, priority flips on ack.
module rsa_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       ack_i,
    output logic [1:0] grant_o
);

    logic last_q;

    // NOTE: combinational block assigns a default first so no latch is inferred.
    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (ack_i) begin
            last_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/rsa_job_scheduler.sv
// Arbitrates two requesters onto one RSA core and sequences inverter/mod-exp phases.
// Optional key cache (skip inverter for repeated p,q) enabled by RSA_KEY_CACHE_EN.
module rsa_job_scheduler
    import rsa_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_p,
    input  logic [2*WIDTH-1:0]   req_q,
    input  logic [1:0]           req_encrypt_decrypt,
    input  logic [4*WIDTH-1:0]   req_msg,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic                 rsp_timeout,
    output logic [2*WIDTH-1:0]   rsp_msg,
    output logic [WIDTH-1:0]     core_p,
    output logic [WIDTH-1:0]     core_q,
    output logic                 core_reset_inverter,
    output logic                 core_reset_mod_exp,
    output logic                 core_encrypt_decrypt,
    output logic [2*WIDTH-1:0]   core_msg_in,
    input  logic                 core_inverter_finish,
    input  logic                 core_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   core_msg_out
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   job_p_q, job_q_q;
    logic               job_mode_q, job_id_q;
    logic [2*WIDTH-1:0] job_msg_q;
    logic [2*WIDTH-1:0] rsp_msg_q, rsp_msg_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic               rsp_id_q, rsp_id_d;

    logic               accept, sel_id, cache_hit, timeout_hit;
    logic [WIDTH-1:0]   in_p, in_q;
    logic [2*WIDTH-1:0] in_msg;

    rsa_rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .en_i    ((state_q == S_IDLE) && !reset),
        .req_i   (req_valid),
        .ack_i   (accept),
        .grant_o (req_ready)
    );

    assign accept      = |(req_valid & req_ready);
    assign sel_id      = req_ready[1];
    assign in_p        = sel_id ? req_p[2*WIDTH-1:WIDTH] : req_p[WIDTH-1:0];
    assign in_q        = sel_id ? req_q[2*WIDTH-1:WIDTH] : req_q[WIDTH-1:0];
    assign in_msg      = sel_id ? req_msg[4*WIDTH-1:2*WIDTH] : req_msg[2*WIDTH-1:0];
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef RSA_KEY_CACHE_EN
    logic [WIDTH-1:0] key_p_q, key_q_q;
    logic             key_valid_q;

    assign cache_hit = key_valid_q && (in_p == key_p_q) && (in_q == key_q_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            key_p_q     <= '0;
            key_q_q     <= '0;
            key_valid_q <= 1'b0;
        end else if (state_q == S_EXP_WAIT && core_mod_exp_finish) begin
            key_p_q     <= job_p_q;
            key_q_q     <= job_q_q;
            key_valid_q <= 1'b1;
        end else if ((state_q == S_INV_WAIT && !core_inverter_finish && timeout_hit) ||
                     (state_q == S_EXP_WAIT && timeout_hit)) begin
            key_valid_q <= 1'b0;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rsp_msg_d     = rsp_msg_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_id_d      = rsp_id_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = cache_hit ? S_EXP_RST : S_INV_RST;
            end
            S_INV_RST:   state_d = S_INV_GUARD;
            S_INV_GUARD: begin
                state_d = S_INV_WAIT;
                cnt_d   = '0;
            end
            S_INV_WAIT: begin
                if (core_inverter_finish) begin
                    state_d = S_EXP_RST;
                end else if (timeout_hit) begin
                    state_d       = S_RESP;
                    rsp_msg_d     = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_id_d      = job_id_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXP_RST:   state_d = S_EXP_GUARD;
            S_EXP_GUARD: begin
                state_d = S_EXP_WAIT;
                cnt_d   = '0;
            end
            S_EXP_WAIT: begin
                // Finish wins over a coincident timeout count.
                if (core_mod_exp_finish) begin
                    state_d       = S_RESP;
                    rsp_msg_d     = core_msg_out;
                    rsp_timeout_d = 1'b0;
                    rsp_id_d      = job_id_q;
                end else if (timeout_hit) begin
                    state_d       = S_RESP;
                    rsp_msg_d     = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_id_d      = job_id_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: job and response registers are reset so core_* and rsp_* read zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            job_p_q       <= '0;
            job_q_q       <= '0;
            job_mode_q    <= 1'b0;
            job_msg_q     <= '0;
            job_id_q      <= 1'b0;
            rsp_msg_q     <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_id_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rsp_msg_q     <= rsp_msg_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_id_q      <= rsp_id_d;
            if (accept) begin
                job_p_q    <= in_p;
                job_q_q    <= in_q;
                job_mode_q <= req_encrypt_decrypt[sel_id];
                job_msg_q  <= in_msg;
                job_id_q   <= sel_id;
            end
        end
    end

    assign rsp_valid            = (state_q == S_RESP);
    assign rsp_msg              = rsp_msg_q;
    assign rsp_timeout          = rsp_timeout_q;
    assign rsp_id               = rsp_id_q;
    assign core_p               = job_p_q;
    assign core_q               = job_q_q;
    assign core_encrypt_decrypt = job_mode_q;
    assign core_msg_in          = job_msg_q;
    assign core_reset_inverter  = (state_q == S_INV_RST);
    assign core_reset_mod_exp   = (state_q == S_EXP_RST);

endmodule
